// File: rtl/mult43_seq_ctrl.sv
// mult43_seq_ctrl
// Sequential shift-and-add multiplier. Each beat folds ROWS rows of the AND
// partial-product matrix (a & {W{b[i]}}) << i into a 2W-bit accumulator.
// BEATS = ceil(W/ROWS) beats give an exact 2W-bit product.
//
// Optional feature: define MULT43_SEQ_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero. Without it, latency is always BEATS
// cycles, which constant-time callers rely on.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid (looked at only in IDLE)
//   in_ready   registered; high in IDLE
//   a, b       W-bit multiplicand / multiplier
//   out_valid  registered; p holds the finished product
//   out_ready  consumer takes p (looked at only in DONE)
//   p          2W-bit product, meaningful while out_valid=1
//   busy       high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | beats in progress
// DONE  | product held on p, out_valid=1 until out_ready

module mult43_seq_ctrl #(
    parameter int W    = 43,
    parameter int ROWS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

    localparam int BEATS = (W + ROWS - 1) / ROWS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   a_sh;
    logic [W-1:0]     b_sh;
    logic [CNT_W-1:0] cnt;

    logic [2*W-1:0]   acc_sum;
    logic [2*W-1:0]   a_next;
    logic [W-1:0]     b_next;
    logic             beat_last;

    // Rows of this beat; shifting b right by ROWS feeds zeros in from the
    // top, so the partial last beat adds nothing for rows past bit W-1.
    always_comb begin
        acc_sum = acc;
        for (int k = 0; k < ROWS; k++) begin
            if (b_sh[k]) begin
                acc_sum = acc_sum + (a_sh << k);
            end
        end
        a_next = a_sh << ROWS;
        b_next = b_sh >> ROWS;
    end

`ifdef MULT43_SEQ_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: nothing more can be added.
    assign beat_last = (cnt == LAST_CNT) || (b_next == '0);
`else
    assign beat_last = (cnt == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= {{W{1'b0}}, a};
                        b_sh     <= b;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= S_RUN;
                        in_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc  <= acc_sum;
                    a_sh <= a_next;
                    b_sh <= b_next;
                    cnt  <= cnt + 1'b1;
                    if (beat_last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    // in_ready rises after this edge, so no accept can
                    // coincide with the output handshake.
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign p    = acc;
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult43_seq_ctrl.sv
module tb_mult43_seq_ctrl;
    localparam int W = 43;

    logic clk = 1'b0;
    logic rst;

    logic           iv1, ir1, ov1, or1, busy1;
    logic [W-1:0]   a1, b1;
    logic [2*W-1:0] p1;

    logic           iv4, ir4, ov4, or4, busy4;
    logic [W-1:0]   a4, b4;
    logic [2*W-1:0] p4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult43_seq_ctrl #(.W(W), .ROWS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .p(p1), .busy(busy1)
    );

    mult43_seq_ctrl #(.W(W), .ROWS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx, yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Cycles from accept to out_valid, from the multiplier value alone.
    function automatic int ref_lat(input logic [W-1:0] y, input int rows);
        int hi;
        hi = -1;
        for (int i = 0; i < W; i++) if (y[i]) hi = i;
`ifdef MULT43_SEQ_EARLY_EXIT_EN
        if (hi < 0) return 1;
        return hi / rows + 1;
`else
        return (W + rows - 1) / rows;
`endif
    endfunction

    function automatic logic get_ov(input int d);
        return (d == 1) ? ov1 : ov4;
    endfunction
    function automatic logic get_ir(input int d);
        return (d == 1) ? ir1 : ir4;
    endfunction
    function automatic logic get_busy(input int d);
        return (d == 1) ? busy1 : busy4;
    endfunction
    function automatic logic [2*W-1:0] get_p(input int d);
        return (d == 1) ? p1 : p4;
    endfunction

    task automatic drive_in(input int d, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        if (d == 1) begin iv1 = v; a1 = x; b1 = y; end
        else        begin iv4 = v; a4 = x; b4 = y; end
    endtask

    task automatic drive_or(input int d, input logic v);
        if (d == 1) or1 = v; else or4 = v;
    endtask

    // Entered just after a falling edge; leaves just after the accept edge.
    task automatic start_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        check($sformatf("%s_ready", tag), 128'(get_ir(d)), 128'(1'b1));
        drive_in(d, 1'b1, x, y);
        @(negedge clk);
        drive_in(d, 1'b0, '0, '0);
    endtask

    task automatic wait_done(input int d, output int cyc);
        cyc = 0;
        while (!get_ov(d) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake(input int d, input string tag);
        drive_or(d, 1'b1);
        @(negedge clk);
        drive_or(d, 1'b0);
        check($sformatf("%s_ov_drop", tag), 128'(get_ov(d)), 128'(1'b0));
        check($sformatf("%s_ir_rise", tag), 128'(get_ir(d)), 128'(1'b1));
    endtask

    task automatic run_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int rows, input string tag);
        int cyc;
        start_op(d, x, y, tag);
        wait_done(d, cyc);
        check($sformatf("%s_lat", tag), 128'(cyc), 128'(ref_lat(y, rows)));
        check($sformatf("%s_p", tag), 128'(get_p(d)), 128'(ref_mul(x, y)));
        handshake(d, tag);
    endtask

    initial begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] max_p;
        int             cyc;
        logic           seen_ov;

        drive_in(1, 1'b0, '0, '0);
        drive_in(4, 1'b0, '0, '0);
        or1 = 1'b0;
        or4 = 1'b0;

        // Reset held 3 cycles with in_valid high: nothing may be accepted.
        rst = 1'b1;
        iv1 = 1'b1;
        iv4 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ir", 128'(ir1), 128'(1'b1));
        check("rst_ov", 128'(ov1), 128'(1'b0));
        check("rst_busy", 128'(busy1), 128'(1'b0));
        check("rst_p", 128'(p1), 128'(0));
        check("rst_p4", 128'(p4), 128'(0));
        rst = 1'b0;
        iv1 = 1'b0;
        iv4 = 1'b0;
        @(negedge clk);
        check("rst_no_accept", 128'(busy1), 128'(1'b0));
        check("rst_no_accept4", 128'(busy4), 128'(1'b0));

        // Maximum operands: p = 2^86 - 2^44 + 1.
        max_p = 86'(0) - (86'(1) << 44) + 86'(1);
        ra = '1;
        start_op(1, ra, ra, "max");
        check("max_busy", 128'(busy1), 128'(1'b1));
        wait_done(1, cyc);
        check("max_lat", 128'(cyc), 128'(ref_lat(ra, 1)));
        check("max_p", 128'(p1), 128'(max_p));
        handshake(1, "max");

        run_op(1, 43'd3, 43'd5, 1, "small");
        run_op(1, 43'd123, 43'd0, 1, "bzero");
        run_op(1, 43'd0, 43'h5A5A5, 1, "azero");

        // Backpressure: out_ready low for 10 cycles, in_valid pulsing.
        start_op(1, 43'h1234567, 43'hABCDEF, "bp");
        wait_done(1, cyc);
        check("bp_lat", 128'(cyc), 128'(ref_lat(43'hABCDEF, 1)));
        for (int i = 0; i < 10; i++) begin
            drive_in(1, i[0], 43'($urandom), 43'($urandom));
            @(negedge clk);
            check("bp_p_hold", 128'(p1), 128'(ref_mul(43'h1234567, 43'hABCDEF)));
            check("bp_ov_hold", 128'(ov1), 128'(1'b1));
            check("bp_ir_low", 128'(ir1), 128'(1'b0));
        end
        drive_in(1, 1'b0, '0, '0);
        handshake(1, "bp");
        check("bp_no_second", 128'(busy1), 128'(1'b0));

        // Reset after 20 beats: back to IDLE with no output.
        start_op(1, 43'h7FFFF, 43'h7FFFFFFFFFF, "abort");
        seen_ov = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_ov = seen_ov | ov1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_no_ov", 128'(seen_ov | ov1), 128'(1'b0));
        check("abort_ir", 128'(ir1), 128'(1'b1));
        check("abort_busy", 128'(busy1), 128'(1'b0));
        run_op(1, 43'd7, 43'd9, 1, "post_abort");

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(0, W - 1);
            run_op(1, ra, rb, 1, "rand1");
        end

        // ROWS=4: 11 beats, the last one covering only bits 40..42.
        run_op(4, 43'd1, 43'd1 << 42, 4, "r4_top");
        run_op(4, '1, '1, 4, "r4_max");
        run_op(4, 43'd3, 43'd5, 4, "r4_small");
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i[1]) rb = rb >> $urandom_range(0, W - 1);
            run_op(4, ra, rb, 4, "rand4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
